// File: rtl/multicycle_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS-subset control sequencer:
// opcodes, state encodings, datapath select codes and the control vector.
package mips_ctrl_pkg;

    // Instruction opcodes (op field of the instruction register)
    localparam logic [5:0] OP_ADD  = 6'b000000;
    localparam logic [5:0] OP_SUB  = 6'b000001;
    localparam logic [5:0] OP_ADDI = 6'b000010;
    localparam logic [5:0] OP_OR   = 6'b010000;
    localparam logic [5:0] OP_AND  = 6'b010001;
    localparam logic [5:0] OP_ORI  = 6'b010010;
    localparam logic [5:0] OP_SLL  = 6'b011000;
    localparam logic [5:0] OP_SLT  = 6'b100110;
    localparam logic [5:0] OP_SW   = 6'b110000;
    localparam logic [5:0] OP_LW   = 6'b110001;
    localparam logic [5:0] OP_BEQ  = 6'b110100;
    localparam logic [5:0] OP_BNE  = 6'b110101;
    localparam logic [5:0] OP_J    = 6'b111000;
    localparam logic [5:0] OP_JR   = 6'b111001;
    localparam logic [5:0] OP_JAL  = 6'b111010;

    // Sequencer states; HALT reuses 3'b000 and is told apart by a flag
    typedef enum logic [2:0] {
        ST_IF      = 3'b000,
        ST_ID      = 3'b001,
        ST_EXE_MEM = 3'b010,
        ST_MEM     = 3'b011,
        ST_WB_LD   = 3'b100,
        ST_EXE_BR  = 3'b101,
        ST_EXE_AL  = 3'b110,
        ST_WB_AL   = 3'b111
    } state_e;

    // ALU operation codes
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_SLL = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_AND = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;

    // Next-PC selects
    localparam logic [1:0] PC_SEQ = 2'b00;
    localparam logic [1:0] PC_BR  = 2'b01;
    localparam logic [1:0] PC_JR  = 2'b10;
    localparam logic [1:0] PC_JMP = 2'b11;

    // Register-file write destination selects
    localparam logic [1:0] DST_RA = 2'b00;
    localparam logic [1:0] DST_RT = 2'b01;
    localparam logic [1:0] DST_RD = 2'b10;

    // Complete set of datapath controls issued each cycle
    typedef struct packed {
        logic       pc_wre;
        logic       ir_wre;
        logic       ins_mem_rw;
        logic       alu_src_a;
        logic       alu_src_b;
        logic [2:0] alu_op;
        logic       ext_sel;
        logic [1:0] reg_dst;
        logic       reg_wre;
        logic       wr_reg_d_src;
        logic       m_rd;
        logic       m_wr;
        logic       db_data_src;
        logic [1:0] pc_src;
    } ctrl_t;

    // Controls held while reset is asserted: only the instruction memory read
    function automatic ctrl_t reset_ctrl();
        ctrl_t c;
        c = '0;
        c.ins_mem_rw = 1'b1;
        return c;
    endfunction

    // Register-register and register-immediate ALU instructions
    function automatic logic is_alu_op(input logic [5:0] op);
        logic r;
        case (op)
            OP_ADD, OP_SUB, OP_ADDI, OP_OR,
            OP_AND, OP_ORI, OP_SLL, OP_SLT: r = 1'b1;
            default:                        r = 1'b0;
        endcase
        return r;
    endfunction

    // Every opcode the sequencer knows, apart from the halt opcode
    function automatic logic is_known_op(input logic [5:0] op);
        logic r;
        case (op)
            OP_SW, OP_LW, OP_BEQ, OP_BNE,
            OP_J, OP_JR, OP_JAL: r = 1'b1;
            default:             r = is_alu_op(op);
        endcase
        return r;
    endfunction

    // Instructions whose second ALU operand is the extended immediate
    function automatic logic uses_imm(input logic [5:0] op);
        logic r;
        case (op)
            OP_ADDI, OP_ORI, OP_LW, OP_SW: r = 1'b1;
            default:                       r = 1'b0;
        endcase
        return r;
    endfunction

    // ALU operation for an opcode; loads, stores and add-type default to add
    function automatic logic [2:0] alu_code(input logic [5:0] op);
        logic [2:0] r;
        case (op)
            OP_SUB, OP_BEQ, OP_BNE: r = ALU_SUB;
            OP_SLL:                 r = ALU_SLL;
            OP_OR, OP_ORI:          r = ALU_OR;
            OP_AND:                 r = ALU_AND;
            OP_SLT:                 r = ALU_SLT;
            default:                r = ALU_ADD;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Control bus between the multi-cycle sequencer (master) and the datapath
// (slave): instruction fields in, every enable and mux select out.
interface multicycle_ctrl_if #(
    parameter int STATE_W = 3
);
    logic [5:0]         op;
    logic               zero;
    logic [STATE_W-1:0] state;
    logic               PCWre;
    logic               IRWre;
    logic               InsMemRW;
    logic               ALUSrcA;
    logic               ALUSrcB;
    logic [2:0]         ALUOp;
    logic               ExtSel;
    logic [1:0]         RegDst;
    logic               RegWre;
    logic               WrRegDSrc;
    logic               mRD;
    logic               mWR;
    logic               DBDataSrc;
    logic [1:0]         PCSrc;

    modport master (
        input  op, zero,
        output state, PCWre, IRWre, InsMemRW, ALUSrcA, ALUSrcB, ALUOp,
               ExtSel, RegDst, RegWre, WrRegDSrc, mRD, mWR, DBDataSrc, PCSrc
    );

    modport slave (
        output op, zero,
        input  state, PCWre, IRWre, InsMemRW, ALUSrcA, ALUSrcB, ALUOp,
               ExtSel, RegDst, RegWre, WrRegDSrc, mRD, mWR, DBDataSrc, PCSrc
    );
endinterface

// File: rtl/multicycle_ctrl_decode.sv
// Combinational control decode: maps the state being entered, its halt flag,
// the instruction opcode and the ALU zero flag to the full control vector.
module ctrl_decode
    import mips_ctrl_pkg::*;
#(
    parameter logic [5:0] HALT_OP = 6'b111111
) (
    input  state_e     ns,
    input  logic       ns_halt,
    input  logic [5:0] op,
    input  logic       zero,
    output ctrl_t      ctrl
);

    logic       alu_src_a_s;
    logic       alu_src_b_s;
    logic       ext_sel_s;
    logic [2:0] alu_op_s;
    logic       br_taken_s;

    assign alu_src_a_s = (op == OP_SLL);
    assign alu_src_b_s = uses_imm(op);
    assign ext_sel_s   = (op != OP_ORI);
    assign alu_op_s    = alu_code(op);
    assign br_taken_s  = ((op == OP_BEQ) && zero) || ((op == OP_BNE) && !zero);

    // Build the control vector for the state about to be entered
    always_comb begin
        ctrl = '0;
        if (ns_halt) begin
            ctrl = '0;
        end else begin
            // ALU operand and operation selects stay steady from EXE through WB
            case (ns)
                ST_EXE_AL, ST_WB_AL, ST_EXE_BR,
                ST_EXE_MEM, ST_MEM, ST_WB_LD: begin
                    ctrl.alu_src_a = alu_src_a_s;
                    ctrl.alu_src_b = alu_src_b_s;
                    ctrl.ext_sel   = ext_sel_s;
                    ctrl.alu_op    = alu_op_s;
                end
                default: begin
                    ctrl.alu_op = ALU_ADD;
                end
            endcase

            case (ns)
                ST_IF: begin
                    ctrl.ins_mem_rw = 1'b1;
                    ctrl.ir_wre     = 1'b1;
                end
                ST_ID: begin
                    case (op)
                        OP_J: begin
                            ctrl.pc_wre = 1'b1;
                            ctrl.pc_src = PC_JMP;
                        end
                        OP_JAL: begin
                            ctrl.pc_wre       = 1'b1;
                            ctrl.pc_src       = PC_JMP;
                            ctrl.reg_wre      = 1'b1;
                            ctrl.reg_dst      = DST_RA;
                            ctrl.wr_reg_d_src = 1'b0;
                        end
                        OP_JR: begin
                            ctrl.pc_wre = 1'b1;
                            ctrl.pc_src = PC_JR;
                        end
                        default: begin
                            // Unknown opcodes retire here as no-ops; halt never advances PC
                            if ((op != HALT_OP) && !is_known_op(op)) begin
                                ctrl.pc_wre = 1'b1;
                            end else begin
                                ctrl.pc_wre = 1'b0;
                            end
                        end
                    endcase
                end
                ST_EXE_AL: begin
                    ctrl.pc_wre = 1'b0;
                end
                ST_WB_AL: begin
                    ctrl.pc_wre       = 1'b1;
                    ctrl.reg_wre      = 1'b1;
                    ctrl.wr_reg_d_src = 1'b1;
                    ctrl.db_data_src  = 1'b0;
                    if ((op == OP_ADDI) || (op == OP_ORI)) begin
                        ctrl.reg_dst = DST_RT;
                    end else begin
                        ctrl.reg_dst = DST_RD;
                    end
                end
                ST_EXE_BR: begin
                    ctrl.pc_wre = 1'b1;
                    if (br_taken_s) begin
                        ctrl.pc_src = PC_BR;
                    end else begin
                        ctrl.pc_src = PC_SEQ;
                    end
                end
                ST_EXE_MEM: begin
                    ctrl.pc_wre = 1'b0;
                end
                ST_MEM: begin
                    if (op == OP_LW) begin
                        ctrl.m_rd = 1'b1;
                    end else if (op == OP_SW) begin
                        ctrl.m_wr   = 1'b1;
                        ctrl.pc_wre = 1'b1;
                    end else begin
                        ctrl.m_rd = 1'b0;
                    end
                end
                ST_WB_LD: begin
                    ctrl.pc_wre       = 1'b1;
                    ctrl.reg_wre      = 1'b1;
                    ctrl.reg_dst      = DST_RT;
                    ctrl.wr_reg_d_src = 1'b1;
                    ctrl.db_data_src  = 1'b1;
                    ctrl.m_rd         = 1'b1;
                end
                default: begin
                    ctrl = '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control sequencer for the MIPS-subset datapath. Steps each
// instruction through IF/ID/EXE/MEM/WB and issues registered Moore controls
// decoded from the state being entered, so they are steady for that state.
module multicycle_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter logic [5:0] HALT_OP = 6'b111111,
    parameter int         STATE_W = 3
) (
    input  logic             CLK,
    input  logic             Reset,
    multicycle_ctrl_if.master bus
);

    state_e     state_r;
    logic       halted_r;
    logic [5:0] op_r;
    ctrl_t      ctrl_r;

    state_e     ns_s;
    logic       ns_halt_s;
    logic [5:0] op_sel_s;
    ctrl_t      ctrl_s;

    // The opcode is live while the instruction is being fetched and decoded
    // (the outputs for ID and for the first EXE step must be set up from it);
    // afterwards the copy captured on leaving ID governs the sequence.
    assign op_sel_s = ((state_r == ST_IF) || (state_r == ST_ID)) ? bus.op : op_r;

    // Next-state selection
    always_comb begin
        ns_s      = ST_IF;
        ns_halt_s = 1'b0;
        case (state_r)
            ST_IF: begin
                ns_s = ST_ID;
            end
            ST_ID: begin
                if (op_sel_s == HALT_OP) begin
                    ns_s      = ST_IF;
                    ns_halt_s = 1'b1;
                end else if ((op_sel_s == OP_BEQ) || (op_sel_s == OP_BNE)) begin
                    ns_s = ST_EXE_BR;
                end else if ((op_sel_s == OP_LW) || (op_sel_s == OP_SW)) begin
                    ns_s = ST_EXE_MEM;
                end else if (is_alu_op(op_sel_s)) begin
                    ns_s = ST_EXE_AL;
                end else begin
                    ns_s = ST_IF;
                end
            end
            ST_EXE_AL:  ns_s = ST_WB_AL;
            ST_WB_AL:   ns_s = ST_IF;
            ST_EXE_BR:  ns_s = ST_IF;
            ST_EXE_MEM: ns_s = ST_MEM;
            ST_MEM: begin
                if (op_sel_s == OP_LW) begin
                    ns_s = ST_WB_LD;
                end else begin
                    ns_s = ST_IF;
                end
            end
            ST_WB_LD:   ns_s = ST_IF;
            default:    ns_s = ST_IF;
        endcase
    end

    ctrl_decode #(
        .HALT_OP (HALT_OP)
    ) u_decode (
        .ns      (ns_s),
        .ns_halt (ns_halt_s),
        .op      (op_sel_s),
        .zero    (bus.zero),
        .ctrl    (ctrl_s)
    );

    // Sequencer state, opcode latch and registered control outputs
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state_r  <= ST_IF;
            halted_r <= 1'b0;
            op_r     <= 6'b000000;
            ctrl_r   <= reset_ctrl();
        end else if (halted_r) begin
            state_r  <= state_r;
            halted_r <= 1'b1;
            op_r     <= op_r;
            ctrl_r   <= ctrl_r;
        end else begin
            state_r  <= ns_s;
            halted_r <= ns_halt_s;
            if (state_r == ST_ID) begin
                op_r <= bus.op;
            end else begin
                op_r <= op_r;
            end
            ctrl_r   <= ctrl_s;
        end
    end

    assign bus.state     = STATE_W'(state_r);
    assign bus.PCWre     = ctrl_r.pc_wre;
    assign bus.IRWre     = ctrl_r.ir_wre;
    assign bus.InsMemRW  = ctrl_r.ins_mem_rw;
    assign bus.ALUSrcA   = ctrl_r.alu_src_a;
    assign bus.ALUSrcB   = ctrl_r.alu_src_b;
    assign bus.ALUOp     = ctrl_r.alu_op;
    assign bus.ExtSel    = ctrl_r.ext_sel;
    assign bus.RegDst    = ctrl_r.reg_dst;
    assign bus.RegWre    = ctrl_r.reg_wre;
    assign bus.WrRegDSrc = ctrl_r.wr_reg_d_src;
    assign bus.mRD       = ctrl_r.m_rd;
    assign bus.mWR       = ctrl_r.m_wr;
    assign bus.DBDataSrc = ctrl_r.db_data_src;
    assign bus.PCSrc     = ctrl_r.pc_src;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed testbench for multicycle_ctrl: walks each instruction class
// through its state sequence and checks the registered controls per state.
module tb_multicycle_ctrl;

    logic CLK;
    logic Reset;
    int   errors;
    int   checks;

    multicycle_ctrl_if #(.STATE_W(3)) bus ();

    multicycle_ctrl #(
        .HALT_OP (6'b111111),
        .STATE_W (3)
    ) dut (
        .CLK   (CLK),
        .Reset (Reset),
        .bus   (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        logic [2:0] exp_st [4];
        exp_st = '{3'b001, 3'b110, 3'b111, 3'b000};
        Reset    = 1'b0;
        bus.op   = 6'b000000;
        bus.zero = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        checks++; if (bus.state !== 3'b000) begin errors++; $display("FAIL reset_state: got %b want 000", bus.state); end
        checks++; if (bus.InsMemRW !== 1'b1) begin errors++; $display("FAIL reset_insmemrw: got %b want 1", bus.InsMemRW); end
        checks++; if (bus.PCWre !== 1'b0) begin errors++; $display("FAIL reset_pcwre: got %b want 0", bus.PCWre); end
        checks++; if (bus.IRWre !== 1'b0) begin errors++; $display("FAIL reset_irwre: got %b want 0", bus.IRWre); end
        @(negedge CLK);
        Reset = 1'b1;
        #1;
        checks++; if (bus.state !== 3'b000) begin errors++; $display("FAIL release_state: got %b want 000", bus.state); end
        for (int i = 0; i < 4; i++) begin
            step();
            checks++; if (bus.state !== exp_st[i]) begin errors++; $display("FAIL reset_seq[%0d]: got %b want %b", i, bus.state, exp_st[i]); end
        end
    endtask

    task automatic test_add();
        logic [2:0] exp_st [4];
        int pulses;
        exp_st = '{3'b001, 3'b110, 3'b111, 3'b000};
        pulses = 0;
        bus.op = 6'b000000;
        for (int i = 0; i < 4; i++) begin
            step();
            // opcode changes after decode must not disturb the add in flight
            if (i == 1) bus.op = 6'b110000;
            checks++; if (bus.state !== exp_st[i]) begin errors++; $display("FAIL add_state[%0d]: got %b want %b", i, bus.state, exp_st[i]); end
            checks++; if (bus.RegWre !== (i == 2)) begin errors++; $display("FAIL add_regwre[%0d]: got %b want %b", i, bus.RegWre, (i == 2)); end
            if (i == 2) begin
                checks++; if (bus.RegDst !== 2'b10) begin errors++; $display("FAIL add_regdst: got %b want 10", bus.RegDst); end
                checks++; if (bus.WrRegDSrc !== 1'b1) begin errors++; $display("FAIL add_wrregdsrc: got %b want 1", bus.WrRegDSrc); end
                checks++; if (bus.DBDataSrc !== 1'b0) begin errors++; $display("FAIL add_dbdatasrc: got %b want 0", bus.DBDataSrc); end
            end
            if (bus.PCWre === 1'b1) pulses++;
        end
        checks++; if (pulses !== 1) begin errors++; $display("FAIL add_pcwre_pulses: got %0d want 1", pulses); end
        checks++; if (bus.IRWre !== 1'b1) begin errors++; $display("FAIL if_irwre: got %b want 1", bus.IRWre); end
        checks++; if (bus.InsMemRW !== 1'b1) begin errors++; $display("FAIL if_insmemrw: got %b want 1", bus.InsMemRW); end
    endtask

    task automatic test_load_store();
        logic [2:0] lw_st [5];
        logic [2:0] sw_st [4];
        int pulses;
        lw_st = '{3'b001, 3'b010, 3'b011, 3'b100, 3'b000};
        sw_st = '{3'b001, 3'b010, 3'b011, 3'b000};
        pulses = 0;
        bus.op = 6'b110001;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++; if (bus.state !== lw_st[i]) begin errors++; $display("FAIL lw_state[%0d]: got %b want %b", i, bus.state, lw_st[i]); end
            checks++; if (bus.mRD !== ((i == 2) || (i == 3))) begin errors++; $display("FAIL lw_mrd[%0d]: got %b want %b", i, bus.mRD, ((i == 2) || (i == 3))); end
            if (i == 1) begin
                checks++; if (bus.ALUSrcB !== 1'b1) begin errors++; $display("FAIL lw_alusrcb: got %b want 1", bus.ALUSrcB); end
                checks++; if (bus.ALUOp !== 3'b000) begin errors++; $display("FAIL lw_aluop: got %b want 000", bus.ALUOp); end
            end
            if (i == 3) begin
                checks++; if (bus.DBDataSrc !== 1'b1) begin errors++; $display("FAIL lw_dbdatasrc: got %b want 1", bus.DBDataSrc); end
                checks++; if (bus.RegDst !== 2'b01) begin errors++; $display("FAIL lw_regdst: got %b want 01", bus.RegDst); end
                checks++; if (bus.RegWre !== 1'b1) begin errors++; $display("FAIL lw_regwre: got %b want 1", bus.RegWre); end
            end
            if (bus.PCWre === 1'b1) pulses++;
        end
        checks++; if (pulses !== 1) begin errors++; $display("FAIL lw_pcwre_pulses: got %0d want 1", pulses); end

        bus.op = 6'b110000;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++; if (bus.state !== sw_st[i]) begin errors++; $display("FAIL sw_state[%0d]: got %b want %b", i, bus.state, sw_st[i]); end
            checks++; if (bus.mWR !== (i == 2)) begin errors++; $display("FAIL sw_mwr[%0d]: got %b want %b", i, bus.mWR, (i == 2)); end
            checks++; if (bus.PCWre !== (i == 2)) begin errors++; $display("FAIL sw_pcwre[%0d]: got %b want %b", i, bus.PCWre, (i == 2)); end
            checks++; if (bus.RegWre !== 1'b0) begin errors++; $display("FAIL sw_regwre[%0d]: got %b want 0", i, bus.RegWre); end
        end
    endtask

    task automatic test_branch();
        logic [5:0] t_op  [4];
        logic       t_z   [4];
        logic [1:0] t_src [4];
        t_op  = '{6'b110100, 6'b110100, 6'b110101, 6'b110101};
        t_z   = '{1'b1, 1'b0, 1'b1, 1'b0};
        t_src = '{2'b01, 2'b00, 2'b00, 2'b01};
        for (int k = 0; k < 4; k++) begin
            bus.op   = t_op[k];
            bus.zero = t_z[k];
            step();
            checks++; if (bus.state !== 3'b001) begin errors++; $display("FAIL br_id_state[%0d]: got %b want 001", k, bus.state); end
            step();
            checks++; if (bus.state !== 3'b101) begin errors++; $display("FAIL br_exe_state[%0d]: got %b want 101", k, bus.state); end
            checks++; if (bus.PCSrc !== t_src[k]) begin errors++; $display("FAIL br_pcsrc[%0d]: got %b want %b", k, bus.PCSrc, t_src[k]); end
            checks++; if (bus.PCWre !== 1'b1) begin errors++; $display("FAIL br_pcwre[%0d]: got %b want 1", k, bus.PCWre); end
            checks++; if (bus.ALUOp !== 3'b001) begin errors++; $display("FAIL br_aluop[%0d]: got %b want 001", k, bus.ALUOp); end
            step();
            checks++; if (bus.state !== 3'b000) begin errors++; $display("FAIL br_if_state[%0d]: got %b want 000", k, bus.state); end
        end
        bus.zero = 1'b0;
    endtask

    task automatic test_jump();
        logic [5:0] t_op  [4];
        logic [1:0] t_src [4];
        logic       t_rw  [4];
        t_op  = '{6'b111010, 6'b111000, 6'b111001, 6'b101010};
        t_src = '{2'b11, 2'b11, 2'b10, 2'b00};
        t_rw  = '{1'b1, 1'b0, 1'b0, 1'b0};
        for (int k = 0; k < 4; k++) begin
            bus.op = t_op[k];
            step();
            checks++; if (bus.state !== 3'b001) begin errors++; $display("FAIL jmp_id_state[%0d]: got %b want 001", k, bus.state); end
            checks++; if (bus.PCWre !== 1'b1) begin errors++; $display("FAIL jmp_pcwre[%0d]: got %b want 1", k, bus.PCWre); end
            checks++; if (bus.PCSrc !== t_src[k]) begin errors++; $display("FAIL jmp_pcsrc[%0d]: got %b want %b", k, bus.PCSrc, t_src[k]); end
            checks++; if (bus.RegWre !== t_rw[k]) begin errors++; $display("FAIL jmp_regwre[%0d]: got %b want %b", k, bus.RegWre, t_rw[k]); end
            if (t_rw[k]) begin
                checks++; if (bus.RegDst !== 2'b00) begin errors++; $display("FAIL jal_regdst: got %b want 00", bus.RegDst); end
                checks++; if (bus.WrRegDSrc !== 1'b0) begin errors++; $display("FAIL jal_wrregdsrc: got %b want 0", bus.WrRegDSrc); end
            end
            step();
            checks++; if (bus.state !== 3'b000) begin errors++; $display("FAIL jmp_if_state[%0d]: got %b want 000", k, bus.state); end
            checks++; if (bus.PCWre !== 1'b0) begin errors++; $display("FAIL jmp_if_pcwre[%0d]: got %b want 0", k, bus.PCWre); end
        end
    endtask

    task automatic test_alu_fields();
        logic [5:0] t_op  [7];
        logic [2:0] t_alu [7];
        logic       t_sa  [7];
        logic       t_sb  [7];
        logic       t_ext [7];
        logic [1:0] t_dst [7];
        t_op  = '{6'b000010, 6'b010010, 6'b011000, 6'b100110, 6'b010001, 6'b000001, 6'b010000};
        t_alu = '{3'b000,    3'b011,    3'b010,    3'b101,    3'b100,    3'b001,    3'b011};
        t_sa  = '{1'b0,      1'b0,      1'b1,      1'b0,      1'b0,      1'b0,      1'b0};
        t_sb  = '{1'b1,      1'b1,      1'b0,      1'b0,      1'b0,      1'b0,      1'b0};
        t_ext = '{1'b1,      1'b0,      1'b1,      1'b1,      1'b1,      1'b1,      1'b1};
        t_dst = '{2'b01,     2'b01,     2'b10,     2'b10,     2'b10,     2'b10,     2'b10};
        for (int k = 0; k < 7; k++) begin
            bus.op = t_op[k];
            step();
            step();
            checks++; if (bus.state !== 3'b110) begin errors++; $display("FAIL alu_exe_state[%0d]: got %b want 110", k, bus.state); end
            checks++; if (bus.ALUOp !== t_alu[k]) begin errors++; $display("FAIL alu_aluop[%0d]: got %b want %b", k, bus.ALUOp, t_alu[k]); end
            checks++; if (bus.ALUSrcA !== t_sa[k]) begin errors++; $display("FAIL alu_srca[%0d]: got %b want %b", k, bus.ALUSrcA, t_sa[k]); end
            checks++; if (bus.ALUSrcB !== t_sb[k]) begin errors++; $display("FAIL alu_srcb[%0d]: got %b want %b", k, bus.ALUSrcB, t_sb[k]); end
            checks++; if (bus.ExtSel !== t_ext[k]) begin errors++; $display("FAIL alu_extsel[%0d]: got %b want %b", k, bus.ExtSel, t_ext[k]); end
            step();
            checks++; if (bus.ALUOp !== t_alu[k]) begin errors++; $display("FAIL alu_wb_aluop[%0d]: got %b want %b", k, bus.ALUOp, t_alu[k]); end
            checks++; if (bus.RegDst !== t_dst[k]) begin errors++; $display("FAIL alu_regdst[%0d]: got %b want %b", k, bus.RegDst, t_dst[k]); end
            step();
        end
    endtask

    task automatic test_halt();
        int bad;
        bad = 0;
        bus.op = 6'b111111;
        step();
        checks++; if (bus.state !== 3'b001) begin errors++; $display("FAIL halt_id_state: got %b want 001", bus.state); end
        checks++; if (bus.PCWre !== 1'b0) begin errors++; $display("FAIL halt_id_pcwre: got %b want 0", bus.PCWre); end
        step();
        bus.op = 6'b000000;
        for (int i = 0; i < 20; i++) begin
            if ((bus.PCWre !== 1'b0) || (bus.IRWre !== 1'b0) || (bus.state !== 3'b000)) bad++;
            step();
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL halt_hold: got %0d bad cycles want 0", bad); end
    endtask

    task automatic test_reset_mid();
        int rw_seen;
        rw_seen = 0;
        @(negedge CLK);
        Reset = 1'b0;
        #1;
        checks++; if (bus.state !== 3'b000) begin errors++; $display("FAIL unhalt_state: got %b want 000", bus.state); end
        @(negedge CLK);
        Reset = 1'b1;
        bus.op = 6'b000000;
        step();
        step();
        checks++; if (bus.state !== 3'b110) begin errors++; $display("FAIL mid_exe_state: got %b want 110", bus.state); end
        @(negedge CLK);
        Reset = 1'b0;
        #1;
        checks++; if (bus.state !== 3'b000) begin errors++; $display("FAIL mid_reset_state: got %b want 000", bus.state); end
        checks++; if (bus.InsMemRW !== 1'b1) begin errors++; $display("FAIL mid_reset_insmemrw: got %b want 1", bus.InsMemRW); end
        for (int i = 0; i < 2; i++) begin
            if (bus.RegWre === 1'b1) rw_seen++;
            step();
        end
        if (bus.RegWre === 1'b1) rw_seen++;
        @(negedge CLK);
        Reset = 1'b1;
        step();
        if (bus.RegWre === 1'b1) rw_seen++;
        checks++; if (bus.state !== 3'b001) begin errors++; $display("FAIL mid_restart_state: got %b want 001", bus.state); end
        checks++; if (rw_seen !== 0) begin errors++; $display("FAIL mid_regwre_seen: got %0d want 0", rw_seen); end
        step();
        step();
        checks++; if (bus.RegWre !== 1'b1) begin errors++; $display("FAIL mid_restart_wb: got %b want 1", bus.RegWre); end
    endtask

    initial begin
        errors   = 0;
        checks   = 0;
        Reset    = 1'b0;
        bus.op   = 6'b000000;
        bus.zero = 1'b0;
        test_reset();
        test_add();
        test_load_store();
        test_branch();
        test_jump();
        test_alu_fields();
        test_halt();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
